// File: rtl/nibble_serial_sub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nibble_serial_sub
// Description : Multi-cycle unsigned subtractor, D = A - B - bin, computed one
//               4-bit nibble per clock (LSB first) through a single borrow
//               stage, with a start/busy/done handshake.
//               Optional feature macro: OVERFLOW_EN (adds the signed overflow
//               output ovf).
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_sub #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   d,
    output logic                   bout
`ifdef OVERFLOW_EN
    ,
    output logic                   ovf
`endif
);

    localparam int c_W  = 4 * NIBBLES;
    localparam int c_IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state_q, w_state_d;
    logic [c_W-1:0]   r_a_q,     w_a_d;
    logic [c_W-1:0]   r_b_q,     w_b_d;
    logic [c_W-1:0]   r_res_q,   w_res_d;
    logic [c_W-1:0]   r_d_q,     w_d_d;
    logic [c_IW-1:0]  r_idx_q,   w_idx_d;
    logic             r_br_q,    w_br_d;
    logic             r_busy_q,  w_busy_d;
    logic             r_done_q,  w_done_d;
    logic             r_bout_q,  w_bout_d;
`ifdef OVERFLOW_EN
    logic             r_ovf_q,   w_ovf_d;
`endif

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [4:0]       w_sub;
    logic [c_W-1:0]   w_res_step;

    // Select the current nibble of each latched operand by the nibble index.
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx_q == c_IW'(n)) begin
                w_a_nib = r_a_q[4*n +: 4];
                w_b_nib = r_b_q[4*n +: 4];
            end
        end
    end

    // 4-bit subtract-with-borrow; bit 4 of the 5-bit result is the borrow-out.
    assign w_sub = {1'b0, w_a_nib} - {1'b0, w_b_nib} - {4'b0000, r_br_q};

    // Result register with the current nibble replaced by this step's difference.
    always_comb begin
        w_res_step = r_res_q;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx_q == c_IW'(n)) begin
                w_res_step[4*n +: 4] = w_sub[3:0];
            end
        end
    end

    // Next-state and next-output computation for the IDLE/RUN/DONE controller.
    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_res_d   = r_res_q;
        w_d_d     = r_d_q;
        w_idx_d   = r_idx_q;
        w_br_d    = r_br_q;
        w_busy_d  = r_busy_q;
        w_done_d  = 1'b0;
        w_bout_d  = r_bout_q;
`ifdef OVERFLOW_EN
        w_ovf_d   = r_ovf_q;
`endif
        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Accept: latch operands, seed the borrow chain with bin.
                    w_state_d = S_RUN;
                    w_a_d     = a;
                    w_b_d     = b;
                    w_idx_d   = '0;
                    w_br_d    = bin;
                    w_busy_d  = 1'b1;
                end else begin
                    w_state_d = S_IDLE;
                    w_busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                w_res_d = w_res_step;
                w_br_d  = w_sub[4];
                if (r_idx_q == c_LAST_IDX) begin
                    // Completion: publish the whole result including the last nibble.
                    w_state_d = S_DONE;
                    w_idx_d   = '0;
                    w_busy_d  = 1'b0;
                    w_done_d  = 1'b1;
                    w_d_d     = w_res_step;
                    w_bout_d  = w_sub[4];
`ifdef OVERFLOW_EN
                    w_ovf_d   = (r_a_q[c_W-1] != r_b_q[c_W-1]) &&
                                (w_res_step[c_W-1] != r_a_q[c_W-1]);
`endif
                end else begin
                    w_idx_d = r_idx_q + c_IW'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    // All controller and datapath state, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= S_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_res_q   <= '0;
            r_d_q     <= '0;
            r_idx_q   <= '0;
            r_br_q    <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_bout_q  <= 1'b0;
`ifdef OVERFLOW_EN
            r_ovf_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_res_q   <= w_res_d;
            r_d_q     <= w_d_d;
            r_idx_q   <= w_idx_d;
            r_br_q    <= w_br_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
            r_bout_q  <= w_bout_d;
`ifdef OVERFLOW_EN
            r_ovf_q   <= w_ovf_d;
`endif
        end
    end

    assign busy = r_busy_q;
    assign done = r_done_q;
    assign d    = r_d_q;
    assign bout = r_bout_q;
`ifdef OVERFLOW_EN
    assign ovf  = r_ovf_q;
`endif

endmodule
`default_nettype wire
